// File: rtl/mont_domain_conv_pkg.sv
// Shared definitions for the Montgomery domain converter and MonMult.
package mont_domain_conv_pkg;

    // Operand width; also the exponent of the Montgomery radix R = 2^MONT_W.
    localparam int MONT_W     = 64;
    // Iteration counter width; 2^MONT_CNT_W must exceed MONT_W.
    localparam int MONT_CNT_W = 7;

    // Converter sequencing: IDLE -> RUN -> FIX -> DONE -> IDLE, or IDLE -> DONE on error.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Conversion direction as carried on the dir pin.
    typedef enum logic {
        DIR_TO_MONT   = 1'b0,
        DIR_FROM_MONT = 1'b1
    } dir_t;

endpackage

// File: rtl/mont_domain_conv_if.sv
// Request/result bundle between the register front-end and the converter.
interface mont_domain_conv_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic             err;

    // Front-end side: issues requests, observes results.
    modport master (
        output start, dir, X, M,
        input  Y, busy, done, err
    );

    // Converter side.
    modport slave (
        input  start, dir, X, M,
        output Y, busy, done, err
    );
endinterface

// File: rtl/mont_domain_conv_cond_sub.sv
// Combinational (WIDTH+1)-bit conditional subtract: y = (a >= m) ? a - m : a.
module mont_cond_sub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] m_i,
    output logic [WIDTH:0] y_o
);
    logic [WIDTH:0] diff;

    // Full-width compare and subtract; no truncation.
    always_comb begin
        diff = a_i - m_i;
        y_o  = (a_i >= m_i) ? diff : a_i;
    end
endmodule

// File: rtl/mont_domain_conv.sv
// Serial conversion of operands into (X*R mod M) and out of (X*R^-1 mod M) the
// Montgomery domain, R = 2^WIDTH.
module mont_domain_conv
    import mont_domain_conv_pkg::*;
#(
    parameter int WIDTH = MONT_W,
    parameter int CNT_W = MONT_CNT_W
) (
    input logic                pclk,
    input logic                reset,
    mont_domain_conv_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] m_q;
    dir_t             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] y_q;
    logic             err_q;

    logic             bad_req;
    logic             accept;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sub_a;
    logic [WIDTH:0]   sub_y;
    logic [WIDTH:0]   red_sum;
    logic [WIDTH:0]   half_step;
    logic [WIDTH:0]   run_d;

    // Request qualification: even modulus or unreduced operand is rejected.
    always_comb begin
        bad_req = ~bus.M[0] | (bus.X >= bus.M);
        accept  = (state_q == ST_IDLE) & bus.start;
    end

    // One shared compare-and-subtract: doubling step in RUN, final correction in FIX.
    always_comb begin
        m_ext = {1'b0, m_q};
        sub_a = (state_q == ST_FIX) ? r_q : {r_q[WIDTH-1:0], 1'b0};
    end

    mont_cond_sub #(
        .WIDTH(WIDTH)
    ) u_cond_sub (
        .a_i(sub_a),
        .m_i(m_ext),
        .y_o(sub_y)
    );

    // Per-iteration update: modular doubling or one bit of Montgomery reduction.
    always_comb begin
        red_sum   = r_q + m_ext;
        half_step = r_q[0] ? (red_sum >> 1) : (r_q >> 1);
        run_d     = (dir_q == DIR_FROM_MONT) ? half_step : sub_y;
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = bad_req ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt_q == LAST_ITER) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy spans RUN through DONE, done is the single DONE cycle.
    always_comb begin
        bus.busy = (state_q != ST_IDLE);
        bus.done = (state_q == ST_DONE);
        bus.Y    = y_q;
        bus.err  = err_q;
    end

    // Datapath: operand capture, iteration, correction and result registers.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_q   <= '0;
            m_q   <= '0;
            dir_q <= DIR_TO_MONT;
            cnt_q <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dir_q <= dir_t'(bus.dir);
                        m_q   <= bus.M;
                        r_q   <= {1'b0, bus.X};
                        cnt_q <= '0;
                        err_q <= bad_req;
                        if (bad_req) begin
                            y_q <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= run_d;
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_FIX: begin
                    r_q <= sub_y;
                    y_q <= sub_y[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_domain_conv.sv
// Randomized self-checking bench for mont_domain_conv against an arithmetic model.
module tb_mont_domain_conv;
    logic pclk  = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 pclk = ~pclk;

    mont_domain_conv_if #(.WIDTH(64)) bus ();

    mont_domain_conv #(
        .WIDTH(64),
        .CNT_W(7)
    ) dut (
        .pclk (pclk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- reference arithmetic ----
    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] m);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, m});
    endfunction

    function automatic logic [63:0] to_ref(input logic [63:0] x, input logic [63:0] m);
        logic [127:0] t;
        t = {x, 64'd0};
        return 64'(t % {64'd0, m});
    endfunction

    // 2^-64 mod m = ((m+1)/2)^64 mod m, by six squarings.
    function automatic logic [63:0] rinv_ref(input logic [63:0] m);
        logic [63:0] r;
        r = (m >> 1) + 64'd1;
        for (int i = 0; i < 6; i++) r = mulmod(r, r, m);
        return r;
    endfunction

    function automatic logic [63:0] from_ref(input logic [63:0] x, input logic [63:0] m);
        return mulmod(x, rinv_ref(m), m);
    endfunction

    function automatic logic [63:0] monmult_ref(input logic [63:0] a, input logic [63:0] b,
                                                input logic [63:0] m);
        return mulmod(mulmod(a, b, m), rinv_ref(m), m);
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Run one conversion; lat = edges after the start edge until done is seen.
    task automatic run_op(input logic d, input logic [63:0] x, input logic [63:0] m,
                          output logic [63:0] y, output logic e, output int lat);
        @(negedge pclk);
        bus.start = 1'b1;
        bus.dir   = d;
        bus.X     = x;
        bus.M     = m;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
        bus.X     = rand64();
        bus.M     = rand64();
        bus.dir   = ~d;
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(posedge pclk);
            #1;
            lat++;
        end
        if (!bus.done) check("done_timeout", 128'(lat), 128'd65);
        y = bus.Y;
        e = bus.err;
        @(posedge pclk);
        #1;
    endtask

    logic [63:0] y, y2, m, x, a, b, am, bm, pm;
    logic        e;
    int          lat, dones, cyc;

    initial begin
        bus.start = 1'b0;
        bus.dir   = 1'b0;
        bus.X     = '0;
        bus.M     = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_Y", 128'(bus.Y), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_err", 128'(bus.err), 128'd0);
        reset = 1'b0;

        // Directed values
        run_op(1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFC5, y, e, lat);
        check("to_1_Y", 128'(y), 128'h3B);
        check("to_1_err", 128'(e), 128'd0);
        check("to_1_lat", 128'(lat), 128'd65);
        run_op(1'b1, 64'h3B, 64'hFFFF_FFFF_FFFF_FFC5, y, e, lat);
        check("from_3b_Y", 128'(y), 128'd1);
        run_op(1'b0, 64'd2, 64'd3, y, e, lat);
        check("to_2m3_Y", 128'(y), 128'd2);
        run_op(1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFC5, y, e, lat);
        check("to_0_Y", 128'(y), 128'd0);
        run_op(1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFC5, y, e, lat);
        check("from_0_Y", 128'(y), 128'd0);
        run_op(1'b0, 64'd0, 64'd1, y, e, lat);
        check("m1_Y", 128'(y), 128'd0);
        check("m1_err", 128'(e), 128'd0);

        // Error cases
        run_op(1'b0, 64'd3, 64'h10, y, e, lat);
        check("even_err", 128'(e), 128'd1);
        check("even_Y", 128'(y), 128'd0);
        check("even_lat", 128'(lat), 128'd0);
        check("err_held", 128'(bus.err), 128'd1);
        run_op(1'b0, 64'h11, 64'h11, y, e, lat);
        check("xeqm_err", 128'(e), 128'd1);
        run_op(1'b0, 64'd5, 64'h11, y, e, lat);
        check("clr_err", 128'(e), 128'd0);
        check("clr_Y", 128'(y), 128'(to_ref(64'd5, 64'h11)));

        // Random round trips against the model
        for (int i = 0; i < 300; i++) begin
            m = rand64() | 64'd1;
            if (i % 4 == 0) m = 64'($urandom_range(1, 1000)) | 64'd1;
            x = rand64() % m;
            run_op(1'b0, x, m, y, e, lat);
            check("rnd_to", 128'(y), 128'(to_ref(x, m)));
            run_op(1'b1, y, m, y2, e, lat);
            check("rnd_rt", 128'(y2), 128'(x));
            check("rnd_err", 128'(e), 128'd0);
        end

        // Domain round trip through a MonMult model
        for (int i = 0; i < 50; i++) begin
            m = rand64() | 64'd1;
            a = rand64() % m;
            b = rand64() % m;
            run_op(1'b0, a, m, am, e, lat);
            run_op(1'b0, b, m, bm, e, lat);
            pm = monmult_ref(am, bm, m);
            run_op(1'b1, pm, m, y, e, lat);
            check("monmult", 128'(y), 128'(mulmod(a, b, m)));
        end

        // Starts while busy, including the DONE cycle, are ignored
        x = 64'h1234_5678_9ABC_DEF0;
        m = 64'hFFFF_FFFF_FFFF_FFC5;
        @(negedge pclk);
        bus.start = 1'b1; bus.dir = 1'b0; bus.X = x; bus.M = m;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        y = '0;
        for (cyc = 1; cyc <= 100; cyc++) begin
            bus.start = (cyc == 10 || cyc == 40);
            bus.X = 64'd7; bus.M = 64'd9; bus.dir = 1'b1;
            @(posedge pclk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                y = bus.Y;
                bus.start = 1'b1;
                @(posedge pclk);
                #1;
                bus.start = 1'b0;
                check("start_in_done", 128'(bus.busy), 128'd0);
                cyc++;
            end
        end
        check("hs_dones", 128'(dones), 128'd1);
        check("hs_Y", 128'(y), 128'(to_ref(x, m)));

        // Reset while RUN has counter 30
        @(negedge pclk);
        bus.start = 1'b1; bus.dir = 1'b0; bus.X = 64'd99; bus.M = m;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
        repeat (30) @(posedge pclk);
        #1;
        reset = 1'b1;
        @(posedge pclk);
        #1;
        check("abort_Y", 128'(bus.Y), 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_done", 128'(bus.done), 128'd0);
        reset = 1'b0;
        dones = 0;
        repeat (80) begin
            @(posedge pclk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", 128'(dones), 128'd0);
        run_op(1'b0, 64'd99, m, y, e, lat);
        check("post_abort_Y", 128'(y), 128'(to_ref(64'd99, m)));
        check("post_abort_lat", 128'(lat), 128'd65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
